mul_unit: RTL

//   Multi-cycle shift-add multiplier in the execute stage, directly downstream of the src1 operand mux.

---
 rtl/mul_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: multi-cycle shift-add multiplier for the execute stage.
//   Supports MUL / MLA / UMULL / SMULL behind a start/busy/done handshake.
//   A request takes WIDTH+2 cycles from the start cycle to the done pulse,
//   whatever the operand values.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request; accepted only in IDLE
//   op         00 MUL, 01 MLA, 10 UMULL, 11 SMULL
//   src1       multiplicand (from the src1 mux)
//   src2       multiplier
//   src3       accumulate addend (MLA only)
//   abort      pipeline flush; cancels the operation in flight
//   busy       high in CALC and FINISH
//   done       one-cycle pulse, result valid
//   result_lo  low word of the product (MLA: low word of product + src3)
//   result_hi  high word of the product for long ops, 0 for MUL/MLA
//   flag_n     sign of the architectural result
//   flag_z     architectural result is zero
//
// State table
//   IDLE   | waiting for start; operands are latched on acceptance
//   CALC   | WIDTH shift-add steps, then one cycle that moves to FINISH
//   FINISH | result presented with done; results and flags are committed

module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] src3,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_UMULL = 2'b10;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   addend;
  logic               neg;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               res_n;
  logic               res_z;

  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic               fin_n;
  logic               fin_z;
  logic               is_long;
  logic               commit;

  // Operand magnitudes for SMULL. Negating the most-negative value yields
  // the same bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    abs1 = src1;
    abs2 = src2;
    if (op == OP_SMULL) begin
      if (src1[WIDTH-1]) abs1 = -src1;
      if (src2[WIDTH-1]) abs2 = -src2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (abort)              state_next = IDLE;
        else if (count == '0)   state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        state_next = IDLE;
        if (!abort) done = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The accumulator is stable throughout FINISH, so the final result is
  // formed combinationally from it and committed on the FINISH edge.
  always_comb begin
    is_long = op_q[1];
    prod    = neg ? (~acc + 1'b1) : acc;
    fin_lo  = prod[WIDTH-1:0];
    if (op_q == OP_MLA) fin_lo = prod[WIDTH-1:0] + addend;
    fin_hi  = is_long ? prod[2*WIDTH-1:WIDTH] : '0;
    fin_n   = is_long ? prod[2*WIDTH-1] : fin_lo[WIDTH-1];
    fin_z   = is_long ? (prod == '0) : (fin_lo == '0);
  end

  assign commit = (state == FINISH) && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MUL;
      mcand  <= '0;
      mplier <= '0;
      addend <= '0;
      neg    <= 1'b0;
      count  <= '0;
      acc    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      res_n  <= 1'b0;
      res_z  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            mcand  <= {{WIDTH{1'b0}}, abs1};
            mplier <= abs2;
            addend <= src3;
            neg    <= (op == OP_SMULL) ? (src1[WIDTH-1] ^ src2[WIDTH-1]) : 1'b0;
            count  <= CW'(WIDTH);
            acc    <= '0;
          end
        end
        CALC: begin
          if (!abort && count != '0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
          end
        end
        FINISH: begin
          if (commit) begin
            res_lo <= fin_lo;
            res_hi <= fin_hi;
            res_n  <= fin_n;
            res_z  <= fin_z;
          end
        end
        default: ;
      endcase
    end
  end

  // During the done cycle the fresh result is forwarded; otherwise the
  // committed registers hold the last completed operation.
  assign result_lo = commit ? fin_lo : res_lo;
  assign result_hi = commit ? fin_hi : res_hi;
  assign flag_n    = commit ? fin_n  : res_n;
  assign flag_z    = commit ? fin_z  : res_z;

endmodule
